tile_cfg_chain: RTL

TILE_CFG_CHAIN -- requirements
Module: tile_cfg_chain

---
 rtl/tile_cfg_chain.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tile_cfg_chain.sv
// Serial configuration chain for one tile: shifts CFG_DEPTH words of CFG_W bits, commits them atomically.
// Optional per-word even parity is enabled with the TILE_CFG_PARITY_EN macro.
module tile_cfg_chain #(
  parameter int CFG_W     = 12,
  parameter int CFG_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 program_mode,
  input  logic                                 jtag_data_in,
  output logic                                 jtag_data_out,
  output logic [CFG_W*CFG_DEPTH-1:0]           cfg_out,
  output logic [$clog2(CFG_DEPTH+1)-1:0]       cfg_word_idx,
  output logic                                 cfg_done,
  output logic                                 cfg_busy,
  output logic                                 parity_err
);

`ifdef TILE_CFG_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int IDX_W = $clog2(CFG_DEPTH + 1);
  localparam int L     = CFG_W + PAR_BITS;
  localparam int CNT_W = $clog2(L);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CFG_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT,
    S_HOLD
  } state_t;

  state_t                         state_q, state_d;
  logic [CFG_W-1:0]               sr_q, sr_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CFG_W*CFG_DEPTH-1:0]     shadow_q, shadow_d;
  logic [CFG_W*CFG_DEPTH-1:0]     cfg_q, cfg_d;
`ifdef TILE_CFG_PARITY_EN
  logic                           perr_q, perr_d;
`endif

  logic [CFG_W-1:0] sr_shift;
  logic [CFG_W-1:0] word;
  logic             par_cycle;
  logic             word_err;
  logic             err_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
`ifdef TILE_CFG_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
`ifdef TILE_CFG_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    cfg_d     = cfg_q;
    sr_shift  = {sr_q[CFG_W-2:0], jtag_data_in};
    word      = sr_shift;
    par_cycle = 1'b0;
    word_err  = 1'b0;
`ifdef TILE_CFG_PARITY_EN
    perr_d    = perr_q;
    // The parity slot holds the shifter still, so the full data word is sr_q.
    par_cycle = (cnt_q == CNT_W'(CFG_W));
    if (par_cycle) word = sr_q;
    word_err  = par_cycle & ((^sr_q) ^ jtag_data_in);
    err_any   = perr_q | word_err;
`else
    err_any   = word_err;
`endif

    case (state_q)
      S_IDLE: begin
        if (program_mode) begin
          state_d  = S_SHIFT;
          sr_d     = {{(CFG_W-1){1'b0}}, jtag_data_in};
          cnt_d    = CNT_W'(1);
          idx_d    = '0;
          shadow_d = '0;
`ifdef TILE_CFG_PARITY_EN
          perr_d   = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        if (!program_mode) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          idx_d    = '0;
          shadow_d = '0;
        end else begin
          if (!par_cycle) sr_d = sr_shift;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            for (int k = 0; k < CFG_DEPTH; k++) begin
              if (idx_q == IDX_W'(k)) shadow_d[k*CFG_W +: CFG_W] = word;
            end
`ifdef TILE_CFG_PARITY_EN
            perr_d = err_any;
`endif
            if (idx_q == IDX_LAST) state_d = err_any ? S_HOLD : S_COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMMIT: begin
        cfg_d   = shadow_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!program_mode) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_busy      = (state_q == S_SHIFT);
  assign cfg_done      = (state_q == S_COMMIT);
  assign jtag_data_out = cfg_busy & ~par_cycle & sr_q[CFG_W-1];
  assign cfg_out       = cfg_q;
  assign cfg_word_idx  = idx_q;
`ifdef TILE_CFG_PARITY_EN
  assign parity_err    = perr_q;
`else
  assign parity_err    = 1'b0;
`endif

endmodule
